// File: rtl/fsm_master.sv
// Single-byte I2C-style bus master: START, 7-bit address + R/W, one data byte, then STOP.
// Optional clock stretching is enabled by defining FSM_MASTER_CLK_STRETCH_EN.
module fsm_master #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl_out,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_select
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WDATA    = 4'd4;
  localparam logic [3:0] S_WACK     = 4'd5;
  localparam logic [3:0] S_RDATA    = 4'd6;
  localparam logic [3:0] S_RNACK    = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [3:0] r_state;
  logic [7:0] r_divCnt;
  logic [1:0] r_quarter;
  logic [2:0] r_bitCnt;
  logic [7:0] r_addrByte;
  logic [7:0] r_wrData;
  logic [7:0] r_rdShift;
  logic [7:0] r_rdData;
  logic       r_busy;
  logic       r_done;
  logic       r_ackErr;

  logic w_quarterEnd;
  logic w_hold;
  logic w_sclOut;
  logic w_sdaOut;
  logic w_sdaSel;

  assign w_quarterEnd = (r_divCnt == DIV_LAST);

`ifdef FSM_MASTER_CLK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the quarter timing.
  assign w_hold = w_sclOut & ~scl_in;
`else
  logic w_unused;
  assign w_unused = scl_in;
  assign w_hold   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_divCnt   <= '0;
      r_quarter  <= '0;
      r_bitCnt   <= '0;
      r_addrByte <= '0;
      r_wrData   <= '0;
      r_rdShift  <= '0;
      r_rdData   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ackErr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_divCnt  <= '0;
        r_quarter <= '0;
        r_bitCnt  <= '0;
        if (start) begin
          r_state    <= S_START;
          r_busy     <= 1'b1;
          r_addrByte <= {addr, rw};
          r_wrData   <= wr_data;
          r_ackErr   <= 1'b0;
        end
      end else if (!w_hold) begin
        if (!w_quarterEnd) begin
          r_divCnt <= r_divCnt + 8'd1;
        end else begin
          r_divCnt  <= '0;
          r_quarter <= r_quarter + 2'd1;
          // Bits are four quarters; sampling happens at the end of Q2, stepping at the end of Q3.
          case (r_state)
            S_START: begin
              if (r_quarter == 2'd1) begin
                r_quarter <= '0;
                r_state   <= S_ADDR;
              end
            end
            S_ADDR, S_WDATA: begin
              if (r_quarter == 2'd3) begin
                r_bitCnt <= r_bitCnt + 3'd1;
                if (r_bitCnt == 3'd7) begin
                  r_state <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WACK;
                end
              end
            end
            S_ADDR_ACK: begin
              if (r_quarter == 2'd2 && sda_in) begin
                r_ackErr <= 1'b1;
              end
              if (r_quarter == 2'd3) begin
                if (r_ackErr) begin
                  r_state <= S_STOP;
                end else begin
                  r_state <= r_addrByte[0] ? S_RDATA : S_WDATA;
                end
              end
            end
            S_WACK: begin
              if (r_quarter == 2'd2 && sda_in) begin
                r_ackErr <= 1'b1;
              end
              if (r_quarter == 2'd3) begin
                r_state <= S_STOP;
              end
            end
            S_RDATA: begin
              if (r_quarter == 2'd2) begin
                r_rdShift <= {r_rdShift[6:0], sda_in};
              end
              if (r_quarter == 2'd3) begin
                r_bitCnt <= r_bitCnt + 3'd1;
                if (r_bitCnt == 3'd7) begin
                  r_rdData <= r_rdShift;
                  r_state  <= S_RNACK;
                end
              end
            end
            S_RNACK: begin
              if (r_quarter == 2'd3) begin
                r_state <= S_STOP;
              end
            end
            S_STOP: begin
              if (r_quarter == 2'd2) begin
                r_quarter <= '0;
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Bus levels are decoded from state and quarter so reset takes effect immediately.
  always_comb begin
    w_sclOut = 1'b1;
    w_sdaOut = 1'b1;
    w_sdaSel = 1'b0;
    case (r_state)
      S_START: begin
        w_sdaSel = 1'b1;
        w_sdaOut = (r_quarter == 2'd0);
      end
      S_ADDR: begin
        w_sclOut = r_quarter[1];
        w_sdaSel = 1'b1;
        w_sdaOut = r_addrByte[3'd7 - r_bitCnt];
      end
      S_WDATA: begin
        w_sclOut = r_quarter[1];
        w_sdaSel = 1'b1;
        w_sdaOut = r_wrData[3'd7 - r_bitCnt];
      end
      S_ADDR_ACK, S_WACK, S_RDATA: begin
        w_sclOut = r_quarter[1];
      end
      S_RNACK: begin
        w_sclOut = r_quarter[1];
        w_sdaSel = 1'b1;
      end
      S_STOP: begin
        w_sclOut = (r_quarter != 2'd0);
        w_sdaSel = 1'b1;
        w_sdaOut = (r_quarter == 2'd2);
      end
      default: begin
        w_sclOut = 1'b1;
        w_sdaOut = 1'b1;
        w_sdaSel = 1'b0;
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign ack_err    = r_ackErr;
  assign rd_data    = r_rdData;
  assign scl_out    = w_sclOut;
  assign sda_out    = w_sdaOut;
  assign sda_select = w_sdaSel;

endmodule

// File: tb/tb_fsm_master.sv
// Scoreboard bench for fsm_master with a behavioural open-drain slave on the bus.
// Expected latency of the stretched transfer depends on FSM_MASTER_CLK_STRETCH_EN.
module tb_fsm_master;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] wr_data = '0;
  logic       scl_in = 1'b1;
  logic       busy, done, ack_err, scl_out, sda_out, sda_select;
  logic [7:0] rd_data;

  logic slaveSda = 1'b1;
  wire  sdaBus = sda_select ? (sda_out & slaveSda) : slaveSda;

  fsm_master #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wr_data(wr_data),
    .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data),
    .scl_out(scl_out), .scl_in(scl_in), .sda_in(sdaBus),
    .sda_out(sda_out), .sda_select(sda_select)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural slave: counts SCL rising edges since the last START condition.
  int         bitIdx = 0;
  logic [7:0] rxAddr = '0;
  logic [7:0] rxData = '0;
  logic       masterNack = 1'b0;
  logic       cfgAckAddr = 1'b1;
  logic       cfgAckData = 1'b1;
  logic [7:0] cfgReadByte = '0;

  always @(negedge sdaBus) if (scl_out) bitIdx = 0;

  always @(posedge scl_out) begin
    bitIdx = bitIdx + 1;
    if (bitIdx <= 8) rxAddr = {rxAddr[6:0], sdaBus};
    else if (bitIdx >= 10 && bitIdx <= 17) rxData = {rxData[6:0], sdaBus};
    else if (bitIdx == 18) masterNack = sdaBus;
  end

  always @(negedge scl_out) begin
    int nxt;
    nxt = bitIdx + 1;
    if (nxt == 9) slaveSda = cfgAckAddr ? 1'b0 : 1'b1;
    else if (nxt >= 10 && nxt <= 17 && rxAddr[0] && cfgAckAddr) slaveSda = cfgReadByte[17 - nxt];
    else if (nxt == 18 && !rxAddr[0] && cfgAckAddr) slaveSda = cfgAckData ? 1'b0 : 1'b1;
    else slaveSda = 1'b1;
  end

  always @(posedge rst) slaveSda = 1'b1;

  typedef struct {
    int         latency;
    logic       ackErr;
    logic [7:0] rdData;
    logic [7:0] addrByte;
    logic [7:0] dataByte;
    logic       isWrite;
    logic       isRead;
    int         busBits;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] expRd = '0;
  int         checks = 0;
  int         failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, "_scl"}, 32'(scl_out), 32'd1);
    checkOutput({tag, "_sda"}, 32'(sda_out), 32'd1);
    checkOutput({tag, "_sel"}, 32'(sda_select), 32'd0);
  endtask

  // Drives one transaction, pushes its expected outcome, then pops and compares on done.
  task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] wd,
                               input logic ackA, input logic ackD, input logic [7:0] rb,
                               input bit stretch, input bit releaseReset);
    exp_t e;
    int   acc;
    int   n;
    bit   got;
    e.addrByte = {a, r};
    e.ackErr   = !ackA || (!r && !ackD);
    e.latency  = (ackA ? 77 : 41) * DIV;
`ifdef FSM_MASTER_CLK_STRETCH_EN
    if (stretch) e.latency += 20;
`endif
    if (r && ackA) expRd = rb;
    e.rdData   = expRd;
    e.dataByte = wd;
    e.isWrite  = !r && ackA;
    e.isRead   = r && ackA;
    e.busBits  = ackA ? 19 : 10;
    expQ.push_back(e);

    cfgAckAddr  = ackA;
    cfgAckData  = ackD;
    cfgReadByte = rb;
    @(negedge clk);
    if (releaseReset) rst = 1'b0;
    addr = a; rw = r; wr_data = wd; start = 1'b1;
    acc = cycle + 1;
    @(negedge clk);
    start = 1'b0; addr = 7'h7F; rw = ~r; wr_data = 8'hFF;
    checkOutput("busyOnAccept", 32'(busy), 32'd1);
    checkOutput("ackErrCleared", 32'(ack_err), 32'd0);

    got = 0;
    n = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      n = cycle - acc;
      if (stretch && n == 16) scl_in = 1'b0;
      if (stretch && n == 36) scl_in = 1'b1;
      if (n == 40) begin start = 1'b1; addr = 7'h11; end
      if (n == 41) start = 1'b0;
      if (done) got = 1;
    end
    start = 1'b0;
    scl_in = 1'b1;

    e = expQ.pop_front();
    if (!got) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(n), 32'(e.latency));
      checkOutput("busyAtDone", 32'(busy), 32'd0);
      checkOutput("ackErr", 32'(ack_err), 32'(e.ackErr));
      checkOutput("rdData", 32'(rd_data), 32'(e.rdData));
      checkOutput("busAddrByte", 32'(rxAddr), 32'(e.addrByte));
      checkOutput("busBitCount", 32'(bitIdx), 32'(e.busBits));
      if (e.isWrite) checkOutput("busDataByte", 32'(rxData), 32'(e.dataByte));
      if (e.isRead) checkOutput("masterNack", 32'(masterNack), 32'd1);
      @(negedge clk);
      checkOutput("donePulse", 32'(done), 32'd0);
      checkIdleBus("afterDone");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstAckErr", 32'(ack_err), 32'd0);
    checkOutput("rstRdData", 32'(rd_data), 32'd0);
    checkIdleBus("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(7'h5A, 1'b0, 8'h2A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(7'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    applyStimulus(7'h5A, 1'b0, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(7'h33, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(7'h2C, 1'b0, 8'hE7, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

    // Abort in the middle of the data byte of a write.
    cfgAckAddr = 1'b1; cfgAckData = 1'b1;
    @(negedge clk);
    addr = 7'h44; rw = 1'b0; wr_data = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    checkOutput("midWdataBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    expRd = 8'h00;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortAckErr", 32'(ack_err), 32'd0);
    checkOutput("abortRdData", 32'(rd_data), 32'd0);
    checkIdleBus("abort");
    applyStimulus(7'h12, 1'b0, 8'h5C, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

    applyStimulus(7'h61, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(7'h61, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(7'h0F, 1'b0, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
